// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Operand feeder for one edge of the TinyTPU systolic MAC array. Buffers up
//   to K_MAX operand vectors (N lanes of D_W bits each) written over a
//   valid/ready port. On start it streams them into the array edge with a
//   diagonal skew: lane i is delayed i cycles. out_init marks each lane's
//   first word so every PE overwrites its accumulator instead of adding to it.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_valid    : write vector offered
//   wr_ready    : feeder can accept a vector (IDLE and not full)
//   wr_data     : vector, lane i = bits [i*D_W +: D_W]
//   start       : begin streaming buffered vectors (sampled in IDLE only)
//   busy        : streaming in progress
//   done        : one-cycle pulse after the last skewed word leaves
//   out_data    : per-lane operand to the array edge (registered)
//   out_init    : per-lane first-word flag to the array edge (registered)
//   count       : vectors currently buffered
module systolic_feeder #(
  parameter int D_W   = 16,
  parameter int N     = 4,
  parameter int K_MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [N*D_W-1:0]             wr_data,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [N*D_W-1:0]             out_data,
  output logic [N-1:0]                 out_init,
  output logic [$clog2(K_MAX+1)-1:0]   count
);

  localparam int CNT_W = $clog2(K_MAX + 1);
  localparam int IDX_W = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  // Step counter must reach K_MAX+N-2 and also hold any buffer length.
  localparam int ST_W  = $clog2(K_MAX + N);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t             state;
  logic [N*D_W-1:0]   mem [K_MAX];
  logic [CNT_W-1:0]   len_q;
  logic [ST_W-1:0]    step_q;
  logic [ST_W-1:0]    last_q;

  logic               wr_accept;
  logic               start_go;
  logic [CNT_W-1:0]   nlen;
  logic [IDX_W-1:0]   wr_idx;
  logic [D_W-1:0]     word0;
  logic [ST_W-1:0]    nxt_step;
  logic [ST_W-1:0]    diff;
  logic [N*D_W-1:0]   nxt_data;
  logic [N-1:0]       nxt_init;

  assign wr_ready  = (state == IDLE) && (count < CNT_W'(K_MAX));
  assign wr_accept = wr_valid && wr_ready;
  assign wr_idx    = count[IDX_W-1:0];
  assign nlen      = count + CNT_W'(wr_accept);
  assign start_go  = start && (state == IDLE) && (nlen != '0);

  // Step 0 is registered on the start edge itself; when the buffer is empty
  // the word being written in that same cycle is the one lane 0 must show.
  assign word0 = (count == '0) ? wr_data[D_W-1:0] : mem[0][D_W-1:0];

  assign nxt_step = step_q + ST_W'(1);

  // Skewed outputs for the next step: lane i shows word (t - i) when it exists.
  always_comb begin
    nxt_data = '0;
    nxt_init = '0;
    diff     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      diff = nxt_step - ST_W'(i);
      if ((nxt_step >= ST_W'(i)) && (diff < ST_W'(len_q))) begin
        nxt_data[i*D_W +: D_W] = mem[diff[IDX_W-1:0]][i*D_W +: D_W];
      end
      if (nxt_step == ST_W'(i)) begin
        nxt_init[i] = 1'b1;
      end
    end
  end

  // Buffer storage carries no reset; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      len_q    <= '0;
      step_q   <= '0;
      last_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_data <= '0;
      out_init <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (wr_accept) begin
            count <= count + CNT_W'(1);
          end
          if (start_go) begin
            state             <= STREAM;
            len_q             <= nlen;
            step_q            <= '0;
            last_q            <= ST_W'(nlen) + ST_W'(N - 2);
            busy              <= 1'b1;
            out_data          <= '0;
            out_data[D_W-1:0] <= word0;
            out_init          <= N'(1);
          end
        end
        STREAM: begin
          if (step_q == last_q) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            out_data <= '0;
            out_init <= '0;
          end else begin
            step_q   <= nxt_step;
            out_data <= nxt_data;
            out_init <= nxt_init;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          count <= '0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          out_data <= '0;
          out_init <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  localparam int D_W   = 16;
  localparam int N     = 4;
  localparam int K_MAX = 8;
  localparam int CNT_W = $clog2(K_MAX + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [N*D_W-1:0]     wr_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [N*D_W-1:0]     out_data;
  logic [N-1:0]         out_init;
  logic [CNT_W-1:0]     count;

  int checks   = 0;
  int failures = 0;

  // Reference buffer: the vectors the feeder should be holding, in order.
  logic [N*D_W-1:0] model_q[$];

  always #5 clk = ~clk;

  systolic_feeder #(.D_W(D_W), .N(N), .K_MAX(K_MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .out_data (out_data),
    .out_init (out_init),
    .count    (count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*D_W-1:0] rand_vec();
    logic [N*D_W-1:0] v;
    for (int i = 0; i < N; i++) v[i*D_W +: D_W] = D_W'($urandom);
    return v;
  endfunction

  // Called just after a rising edge with the feeder idle.
  task automatic push_vec(input logic [N*D_W-1:0] v);
    wr_valid = 1'b1;
    wr_data  = v;
    @(posedge clk);
    if (model_q.size() < K_MAX) model_q.push_back(v);
    #1 wr_valid = 1'b0;
  endtask

  // Pulse start (optionally with a same-cycle write) and check every cycle of
  // the job against the timing rules: lane i word k at C0+1+k+i, init[i] at
  // C0+1+i, busy over C0+1..C0+L+N-1, done at C0+L+N, ready again at C0+L+N+1.
  task automatic stream_job(input string name, input bit restart_mid,
                            input bit with_write, input logic [N*D_W-1:0] wvec);
    int L;
    int k;
    logic [N*D_W-1:0] exp_data;
    logic [N*D_W-1:0] vec;
    logic [N-1:0]     exp_init;
    start = 1'b1;
    if (with_write) begin
      wr_valid = 1'b1;
      wr_data  = wvec;
    end
    @(posedge clk);
    if (with_write && model_q.size() < K_MAX) model_q.push_back(wvec);
    #1;
    start    = 1'b0;
    wr_valid = 1'b0;
    L = model_q.size();
    for (int c = 1; c <= L + N + 1; c++) begin
      @(negedge clk);
      exp_data = '0;
      exp_init = '0;
      for (int i = 0; i < N; i++) begin
        k = c - 1 - i;
        if (k >= 0 && k < L) begin
          vec = model_q[k];
          exp_data[i*D_W +: D_W] = vec[i*D_W +: D_W];
        end
        if (k == 0) exp_init[i] = 1'b1;
      end
      checks++;
      if (out_data !== exp_data) begin
        failures++;
        $display("FAIL %s out_data C0+%0d got=%h exp=%h", name, c, out_data, exp_data);
      end
      checks++;
      if (out_init !== exp_init) begin
        failures++;
        $display("FAIL %s out_init C0+%0d got=%b exp=%b", name, c, out_init, exp_init);
      end
      checks++;
      if (busy !== (c <= L + N - 1)) begin
        failures++;
        $display("FAIL %s busy C0+%0d got=%b exp=%b", name, c, busy, (c <= L + N - 1));
      end
      checks++;
      if (done !== (c == L + N)) begin
        failures++;
        $display("FAIL %s done C0+%0d got=%b exp=%b", name, c, done, (c == L + N));
      end
      if (c == L + N + 1) begin
        checks++;
        if (wr_ready !== 1'b1 || count !== '0) begin
          failures++;
          $display("FAIL %s after_done got ready=%b count=%0d exp ready=1 count=0",
                   name, wr_ready, count);
        end
      end else if (c < L + N + 1) begin
        checks++;
        if (wr_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s ready_in_job C0+%0d got=%b exp=0", name, c, wr_ready);
        end
      end
      if (restart_mid) begin
        if (c == 2) start = 1'b1;
        else if (c == 3) start = 1'b0;
      end
    end
    model_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_data !== '0 || out_init !== '0 || busy !== 1'b0 || done !== 1'b0 || count !== '0) begin
      failures++;
      $display("FAIL reset_hold got data=%h init=%b busy=%b done=%b count=%0d exp all 0",
               out_data, out_init, busy, done, count);
    end
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (wr_ready !== 1'b1 || count !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b count=%0d busy=%b done=%b exp 1/0/0/0",
               wr_ready, count, busy, done);
    end
  endtask

  task automatic test_load_stream();
    logic [N*D_W-1:0] v;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) v[i*D_W +: D_W] = D_W'(k * 16 + i);
      push_vec(v);
    end
    checks++;
    if (count !== CNT_W'(3)) begin
      failures++;
      $display("FAIL load_count got=%0d exp=3", count);
    end
    stream_job("load_stream", 1'b0, 1'b0, '0);
  endtask

  task automatic test_full_buffer();
    for (int n = 0; n < 12; n++) begin
      checks++;
      if (wr_ready !== (model_q.size() < K_MAX)) begin
        failures++;
        $display("FAIL full_ready cycle=%0d got=%b exp=%b", n, wr_ready, (model_q.size() < K_MAX));
      end
      push_vec(rand_vec());
    end
    checks++;
    if (count !== CNT_W'(K_MAX) || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_state got count=%0d ready=%b exp count=%0d ready=0", count, wr_ready, K_MAX);
    end
    stream_job("full_buffer", 1'b0, 1'b0, '0);
  endtask

  task automatic test_empty_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_init !== '0 || wr_ready !== 1'b1) begin
        failures++;
        $display("FAIL empty_start C0+%0d got busy=%b done=%b init=%b ready=%b exp 0/0/0/1",
                 c, busy, done, out_init, wr_ready);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_while_busy();
    for (int k = 0; k < 4; k++) push_vec(rand_vec());
    stream_job("start_while_busy", 1'b1, 1'b0, '0);
  endtask

  task automatic test_write_and_start();
    push_vec(rand_vec());
    push_vec(rand_vec());
    stream_job("write_and_start", 1'b0, 1'b1, rand_vec());
  endtask

  task automatic test_reset_mid_stream();
    for (int k = 0; k < 3; k++) push_vec(rand_vec());
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_data !== '0 || out_init !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs got data=%h init=%b busy=%b done=%b exp all 0",
               out_data, out_init, busy, done);
    end
    #5 rst_n = 1'b1;
    #1;
    checks++;
    if (wr_ready !== 1'b1 || count !== '0) begin
      failures++;
      $display("FAIL reset_mid_release got ready=%b count=%0d exp ready=1 count=0", wr_ready, count);
    end
    model_q.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
        failures++;
        $display("FAIL reset_mid_quiet cycle=%0d got done=%b busy=%b data=%h exp 0/0/0",
                 c, done, busy, out_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    push_vec(rand_vec());
    push_vec(rand_vec());
    stream_job("back_to_back_1", 1'b0, 1'b0, '0);
    push_vec(rand_vec());
    stream_job("back_to_back_2", 1'b0, 1'b0, '0);
  endtask

  task automatic test_random_jobs();
    int L;
    bit ww;
    for (int j = 0; j < 10; j++) begin
      L  = $urandom_range(1, K_MAX);
      ww = 1'($urandom_range(0, 1));
      for (int k = 0; k < L - int'(ww); k++) push_vec(rand_vec());
      stream_job("random_job", 1'($urandom_range(0, 1)), ww, rand_vec());
    end
  endtask

  initial begin
    wr_valid = 1'b0;
    wr_data  = '0;
    start    = 1'b0;
    test_reset();
    test_load_stream();
    test_full_buffer();
    test_empty_start();
    test_start_while_busy();
    test_write_and_start();
    test_reset_mid_stream();
    test_back_to_back();
    test_random_jobs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand feeder for one edge of the TinyTPU systolic MAC array. It buffers up to K_MAX operand vectors, each N lanes wide, written over a valid/ready port. On `start` it streams them into the array edge with the diagonal skew the array requires: lane i is delayed i cycles. It drives the per-lane `init` flag on each lane's first word so every processing element overwrites its accumulator instead of adding to it. One instance feeds the X edge (rows) and one feeds the Y edge (columns).

## Interface
- `D_W`, 16, operand width per lane
- `N`, 4, number of lanes (array edge length)
- `K_MAX`, 8, buffer depth (max inner dimension per job)
- `clk` in 1, clock
- `rst_n` in 1, asynchronous active-low reset
- `wr_valid` in 1, write vector offered
- `wr_ready` out 1, feeder can accept a vector
- `wr_data` in N*D_W, vector; lane i = bits [i*D_W +: D_W]
- `start` in 1, begin streaming buffered vectors (single-cycle sample)
- `busy` out 1, streaming in progress
- `done` out 1, one-cycle pulse after the last skewed word leaves
- `out_data` out N*D_W, lane i operand to array edge
- `out_init` out N, lane i first-word flag to array edge
- `count` out $clog2(K_MAX+1), vectors currently buffered

## Operation
- Reset state, forced asynchronously when `rst_n`=0:
  - state IDLE, `count`=0, `out_data`=0, `out_init`=0, `busy`=0, `done`=0
  - `wr_ready`=1 once `rst_n` deasserts
  - buffer contents are don't-care
- States: IDLE, STREAM, DONE.
- IDLE:
  - `wr_ready` = (`count` < K_MAX).
  - When `wr_valid` and `wr_ready` are both high, `wr_data` is stored at index `count`, and `count` increments.
  - When `start`=1 and the effective length L is at least 1, the block latches L and goes to STREAM. L = `count`, plus 1 if a write is accepted in the same cycle; that write is included.
  - When `start`=1 and L=0, `start` is ignored and the state stays IDLE.
- STREAM:
  - Step counter t runs 0 .. L+N-2 (L+N-1 steps total). `busy`=1 and `wr_ready`=0. `start` is ignored.
  - At step t, lane i outputs `buf[t-i][i]` when 0 ≤ t-i < L; otherwise it outputs 0.
  - `out_init[i]`=1 exactly when t-i = 0; otherwise it is 0.
  - After step L+N-2, the state goes to DONE.
- DONE:
  - Lasts one cycle: `done`=1, `busy`=0, `out_data`=0, `out_init`=0.
  - `count` clears to 0 and the state goes to IDLE.
  - `wr_ready`=0 during DONE.
- Outputs are registered. Outside STREAM, `out_data` and `out_init` are 0.
- Data passes through unmodified; there is no arithmetic on operands.
- Buffer full: when `count`=K_MAX, `wr_ready`=0 and `wr_valid` is ignored with no overwrite.
- When `rst_n` asserts mid-STREAM, outputs zero immediately and the buffered job is discarded.

## Timing
- Cycle numbering: C0 is the cycle in which `start` is sampled high in IDLE with L ≥ 1.
- Lane i word k is valid on `out_data` during cycle C0+1+k+i.
- `out_init[i]` is high during cycle C0+1+i.
- `busy` is high for cycles C0+1 .. C0+L+N-1.
- `done` is high in cycle C0+L+N.
- `wr_ready` returns to 1 in cycle C0+L+N+1.
- Write handshake:
  - A transfer occurs on the rising edge when `wr_valid`&&`wr_ready`.
  - `wr_ready` depends only on state and `count`, never on `wr_valid`.
  - `count` updates in the cycle after the accepting edge.
- Throughput: one vector per cycle accepted in IDLE; one skew step per cycle in STREAM; no bubbles inside a job.
- Minimum job turnaround is L+N+1 cycles from `start` to the next accepted write.

## Test plan
- Load stream, N=4, L=3:
  - Stimulus: write vectors v_k with lane i = 16'h(k*16+i) for k=0..2, then pulse `start`.
  - Lane 0: 0000, 0010, 0020 in C0+1..C0+3.
  - Lane 3: 0003, 0013, 0023 in C0+4..C0+6.
  - `out_init` = 0001, 0010, 0100, 1000 (lane-indexed bits) in C0+1..C0+4.
  - `done` in C0+7.
- Full buffer and back-pressure:
  - Stimulus: hold `wr_valid`=1 for 12 cycles.
  - Exactly 8 vectors accepted, `count`=8, `wr_ready`=0.
  - `start` then streams 8 words per lane; `done` at C0+12.
- Empty start and start while busy:
  - `start` with `count`=0 leaves `busy`=0 and `done` never pulses.
  - A second `start` pulse mid-STREAM does not extend or restart the job; `done` still pulses once at C0+L+N.
- Simultaneous write and start:
  - Stimulus: `count`=2, then `wr_valid` and `start` in the same cycle.
  - L=3; the third vector appears on lane 0 at C0+3.
- Reset mid-stream:
  - Stimulus: assert `rst_n`=0 at C0+2 for one cycle, not aligned to `clk`.
  - Outputs go to 0 immediately; `count`=0, `wr_ready`=1 after release; no `done` pulse.
- Back-to-back jobs:
  - Stimulus: run job L=2, then job L=1.
  - The second job's `out_init` starts a fresh diagonal and no first-job data leaks into it.
